// File: rtl/dmem_arbiter_pkg.sv
// Shared types, width codes and request-legality helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int ARB_ADDR_W = 10;
    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    localparam logic [2:0] MEM_W_B = 3'd0;
    localparam logic [2:0] MEM_W_H = 3'd1;
    localparam logic [2:0] MEM_W_W = 3'd2;
    localparam logic [2:0] MEM_W_D = 3'd3;

    // Codes 4..7 are reserved and never reach the memory.
    function automatic logic width_legal(input logic [2:0] width);
        return ~width[2];
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] width, input logic [2:0] addr_lsb);
        logic mis;
        mis = 1'b0;
        case (width)
            MEM_W_H: mis = addr_lsb[0];
            MEM_W_W: mis = |addr_lsb[1:0];
            MEM_W_D: mis = |addr_lsb;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Per-requester request/response bundle; master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [2:0]        width;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;
    logic              resp_err;

    modport master (
        output valid, we, width, addr, wdata,
        input  ready, resp_valid, rdata, resp_err
    );

    modport slave (
        input  valid, we, width, addr, wdata,
        output ready, resp_valid, rdata, resp_err
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, on contention the port
// that did not win last time is chosen.
module dmem_rr_pick (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);
    assign o_grant[0] = i_valid[0] & (~i_valid[1] |  i_last_grant);
    assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last_grant);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory, one transaction in flight.
// Optional build macro DMEM_ARB_MISALIGN_CHK_EN rejects width-misaligned addresses.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [2:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic              r_last_grant;
    logic              r_req_port;
    logic              r_req_we;
    logic [2:0]        r_req_width;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic [DATA_W-1:0] r_rdata_q;

    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic              w_hs;
    logic              w_err;
    logic              w_access;
    logic              w_issue;
    logic              w_resp;

    assign w_valid = {p1.valid, p0.valid};

    dmem_rr_pick u_pick (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Any valid request in IDLE is granted, so the handshake needs no ready feedback.
    assign w_hs = rst && (r_state == ARB_IDLE) && (|w_valid);

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    assign w_err = ~width_legal(r_req_width) | addr_misaligned(r_req_width, r_req_addr[2:0]);
`else
    assign w_err = ~width_legal(r_req_width);
`endif
    assign w_access = ~w_err;

    assign w_issue = rst && (r_state == ARB_ISSUE);
    assign w_resp  = rst && (r_state == ARB_RESP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= 1'b1;
            r_req_port   <= 1'b0;
            r_req_we     <= 1'b0;
            r_req_width  <= '0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_rdata_q    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_hs) begin
                r_last_grant <= w_grant[1];
                r_req_port   <= w_grant[1];
                r_req_we     <= w_grant[1] ? p1.we    : p0.we;
                r_req_width  <= w_grant[1] ? p1.width : p0.width;
                r_req_addr   <= w_grant[1] ? p1.addr  : p0.addr;
                r_req_wdata  <= w_grant[1] ? p1.wdata : p0.wdata;
            end
            if (r_state == ARB_ISSUE) begin
                r_rdata_q <= (w_access && !r_req_we) ? mem_rdata : '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ARB_IDLE:  if (|w_valid) w_state_next = ARB_ISSUE;
            ARB_ISSUE: w_state_next = ARB_RESP;
            ARB_RESP:  w_state_next = ARB_IDLE;
            default:   w_state_next = ARB_IDLE;
        endcase
    end

    assign p0.ready = w_hs & w_grant[0];
    assign p1.ready = w_hs & w_grant[1];

    assign p0.resp_valid = w_resp & ~r_req_port;
    assign p1.resp_valid = w_resp &  r_req_port;
    assign p0.rdata      = p0.resp_valid ? r_rdata_q : '0;
    assign p1.rdata      = p1.resp_valid ? r_rdata_q : '0;
    assign p0.resp_err   = p0.resp_valid & w_err;
    assign p1.resp_err   = p1.resp_valid & w_err;

    // Strobes and the held request are gated by rst so nothing reaches memory during reset.
    assign mem_we    = w_issue & w_access &  r_req_we;
    assign mem_re    = w_issue & w_access & ~r_req_we;
    assign mem_width = rst ? r_req_width : '0;
    assign mem_addr  = rst ? r_req_addr  : '0;
    assign mem_wdata = rst ? r_req_wdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 10;
    localparam int DW = 64;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [2:0]  width;
        logic [9:0]  addr;
        logic [63:0] wdata;
    } req_t;

    typedef struct packed {
        logic        port;
        req_t        req;
        logic        exp_acc;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_mem = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();

    logic [2:0]    mem_width;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0),
        .p1        (p1),
        .mem_width (mem_width),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [63:0] byte_mask(input logic [2:0] w);
        case (w)
            3'd0:    return 64'h0000_0000_0000_00FF;
            3'd1:    return 64'h0000_0000_0000_FFFF;
            3'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Data memory seen by the DUT: word array, combinational read, byte-lane write.
    logic [63:0] env_mem [0:1023];
    assign mem_rdata = env_mem[mem_addr] & byte_mask(mem_width);
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= 64'd0;
        end else if (mem_we) begin
            env_mem[mem_addr] <= (env_mem[mem_addr] & ~byte_mask(mem_width)) |
                                 (mem_wdata & byte_mask(mem_width));
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int port, input logic v, input req_t r);
        if (port == 0) begin
            p0.valid = v; p0.we = r.we; p0.width = r.width; p0.addr = r.addr; p0.wdata = r.wdata;
        end else begin
            p1.valid = v; p1.we = r.we; p1.width = r.width; p1.addr = r.addr; p1.wdata = r.wdata;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? p0.ready : p1.ready;
    endfunction
    function automatic logic rvld(input int p);
        return (p == 0) ? p0.resp_valid : p1.resp_valid;
    endfunction
    function automatic logic [63:0] rdat(input int p);
        return (p == 0) ? p0.rdata : p1.rdata;
    endfunction
    function automatic logic rerr(input int p);
        return (p == 0) ? p0.resp_err : p1.resp_err;
    endfunction

    function automatic req_t mk_req(input logic we, input logic [2:0] w, input logic [9:0] a,
                                    input logic [63:0] d);
        req_t r;
        r.we = we; r.width = w; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic port, input req_t r, input logic acc,
                                    input logic err, input logic [63:0] rd);
        vec_t v;
        v.port = port; v.req = r; v.exp_acc = acc; v.exp_err = err; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Single isolated transaction: IDLE handshake, ISSUE, RESP, back to IDLE.
    task automatic do_txn(input vec_t v, input string tag);
        int p;
        int o;
        p = int'(v.port);
        o = 1 - p;
        @(negedge clk);
        drive(p, 1'b1, v.req);
        #1;
        check({tag, "_ready"}, rdy(p), 1'b1);
        @(negedge clk);
        drive(p, 1'b0, v.req);
        #1;
        check({tag, "_mem_we"}, mem_we, v.req.we & v.exp_acc);
        check({tag, "_mem_re"}, mem_re, ~v.req.we & v.exp_acc);
        check({tag, "_mem_addr"}, mem_addr, v.req.addr);
        @(negedge clk);
        #1;
        check({tag, "_resp_valid"}, rvld(p), 1'b1);
        check({tag, "_other_resp_valid"}, rvld(o), 1'b0);
        check({tag, "_rdata"}, rdat(p), v.exp_rdata);
        check({tag, "_resp_err"}, rerr(p), v.exp_err);
        $display("txn %s port=%0d we=%0d width=%0d addr=%0d rdata=0x%0h err=%0d",
                 tag, p, v.req.we, v.req.width, v.req.addr, rdat(p), rerr(p));
        @(negedge clk);
        #1;
        check({tag, "_resp_done"}, rvld(p), 1'b0);
    endtask

    vec_t vecs [0:12];

    // Transaction-level reference model for the randomized run.
    req_t        rq [2];
    bit          pend [2];
    logic [63:0] ref_mem [0:15];
    int          phase;
    int          lastg;
    int          cur_port;
    bit          cur_we;
    bit          cur_acc;
    bit          cur_err;
    logic [63:0] cur_rdata;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_t ra;
        req_t rb;
        int   g;
        int   nb;
        bit   rv;

        vecs[0]  = mk_vec(1'b0, mk_req(1'b1, 3'd3, 10'd8,  64'h1122334455667788), 1'b1, 1'b0, 64'h0);
        vecs[1]  = mk_vec(1'b0, mk_req(1'b0, 3'd3, 10'd8,  64'h0), 1'b1, 1'b0, 64'h1122334455667788);
        vecs[2]  = mk_vec(1'b1, mk_req(1'b1, 3'd1, 10'd2,  64'hFFFF_0000_0000_A5A5), 1'b1, 1'b0, 64'h0);
        vecs[3]  = mk_vec(1'b1, mk_req(1'b0, 3'd0, 10'd2,  64'h0), 1'b1, 1'b0, 64'h0000_0000_0000_00A5);
        vecs[4]  = mk_vec(1'b1, mk_req(1'b0, 3'd1, 10'd2,  64'h0), 1'b1, 1'b0, 64'h0000_0000_0000_A5A5);
        vecs[5]  = mk_vec(1'b0, mk_req(1'b1, 3'd5, 10'd24, 64'hCAFE), 1'b0, 1'b1, 64'h0);
        vecs[6]  = mk_vec(1'b0, mk_req(1'b0, 3'd3, 10'd24, 64'h0), 1'b1, 1'b0, 64'h0);
        vecs[7]  = mk_vec(1'b0, mk_req(1'b1, 3'd0, 10'd6,  64'h0123_4567_89AB_CDEF), 1'b1, 1'b0, 64'h0);
        vecs[8]  = mk_vec(1'b0, mk_req(1'b0, 3'd2, 10'd6,  64'h0), ~MIS, MIS, MIS ? 64'h0 : 64'hEF);
        vecs[9]  = mk_vec(1'b1, mk_req(1'b1, 3'd2, 10'd16, 64'hAAAA_BBBB_1234_5678), 1'b1, 1'b0, 64'h0);
        vecs[10] = mk_vec(1'b1, mk_req(1'b0, 3'd1, 10'd16, 64'h0), 1'b1, 1'b0, 64'h5678);
        vecs[11] = mk_vec(1'b1, mk_req(1'b0, 3'd7, 10'd16, 64'h0), 1'b0, 1'b1, 64'h0);
        vecs[12] = mk_vec(1'b0, mk_req(1'b0, 3'd3, 10'd16, 64'h0), 1'b1, 1'b0, 64'h1234_5678);

        // Reset state, with both requesters asserting valid during reset.
        drive(0, 1'b1, mk_req(1'b1, 3'd3, 10'd5, 64'h55));
        drive(1, 1'b1, mk_req(1'b0, 3'd2, 10'd7, 64'h77));
        repeat (3) @(negedge clk);
        #1;
        check("rst_p0_ready", p0.ready, 1'b0);
        check("rst_p1_ready", p1.ready, 1'b0);
        check("rst_p0_resp_valid", p0.resp_valid, 1'b0);
        check("rst_p1_resp_valid", p1.resp_valid, 1'b0);
        check("rst_p0_rdata", p0.rdata, 64'h0);
        check("rst_p1_rdata", p1.rdata, 64'h0);
        check("rst_p0_err", p0.resp_err, 1'b0);
        check("rst_p1_err", p1.resp_err, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_mem_addr", mem_addr, 10'd0);
        check("rst_mem_width", mem_width, 3'd0);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        clr_mem = 1'b0;
        rst = 1'b1;

        for (int i = 0; i <= 12; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Both valid right after reset: p0 first, then p1, then p0 again.
        do_reset();
        ra = mk_req(1'b0, 3'd3, 10'd8, 64'h0);
        rb = mk_req(1'b0, 3'd2, 10'd16, 64'h0);
        @(negedge clk);
        drive(0, 1'b1, ra);
        drive(1, 1'b1, rb);
        #1;
        check("rr_first_p0_ready", p0.ready, 1'b1);
        check("rr_first_p1_ready", p1.ready, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, ra);
        #1;
        check("rr_issue_p1_ready", p1.ready, 1'b0);
        @(negedge clk);
        #1;
        check("rr_resp_p0_valid", p0.resp_valid, 1'b1);
        check("rr_resp_p0_rdata", p0.rdata, 64'h1122334455667788);
        check("rr_resp_p1_ready", p1.ready, 1'b0);
        @(negedge clk);
        #1;
        check("rr_second_p1_ready", p1.ready, 1'b1);
        check("rr_second_p0_ready", p0.ready, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, rb);
        @(negedge clk);
        #1;
        check("rr_resp_p1_valid", p1.resp_valid, 1'b1);
        check("rr_resp_p1_rdata", p1.rdata, 64'h1234_5678);
        check("rr_resp_p1_p0_quiet", p0.resp_valid, 1'b0);
        $display("txn rr pair: p0 load addr 8 then p1 load addr 16");
        @(negedge clk);
        drive(0, 1'b1, ra);
        drive(1, 1'b1, rb);
        #1;
        check("rr_alt_p0_ready", p0.ready, 1'b1);
        check("rr_alt_p1_ready", p1.ready, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, ra);
        drive(1, 1'b0, rb);
        @(negedge clk);
        #1;
        check("rr_alt_p0_resp", p0.resp_valid, 1'b1);
        $display("txn rr alternation: p0 wins after p1");
        @(negedge clk);

        // Reset while a p0 store is in ISSUE: no commit, no response, grant back to p0.
        do_reset();
        ra = mk_req(1'b1, 3'd3, 10'd4, 64'hDEAD_BEEF_0BAD_F00D);
        @(negedge clk);
        drive(0, 1'b1, ra);
        #1;
        check("rstmid_ready", p0.ready, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, ra);
        rst = 1'b0;
        #1;
        check("rstmid_mem_we_gated", mem_we, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        ra = mk_req(1'b0, 3'd3, 10'd4, 64'h0);
        rb = mk_req(1'b0, 3'd3, 10'd16, 64'h0);
        drive(0, 1'b1, ra);
        drive(1, 1'b1, rb);
        #1;
        check("rstmid_no_resp_p0", p0.resp_valid, 1'b0);
        check("rstmid_no_resp_p1", p1.resp_valid, 1'b0);
        check("rstmid_next_p0_ready", p0.ready, 1'b1);
        check("rstmid_next_p1_ready", p1.ready, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, ra);
        drive(1, 1'b0, rb);
        @(negedge clk);
        #1;
        check("rstmid_readback_valid", p0.resp_valid, 1'b1);
        check("rstmid_readback_rdata", p0.rdata, 64'h0);
        check("rstmid_readback_err", p0.resp_err, 1'b0);
        $display("txn reset-in-issue: readback addr 4 rdata=0x%0h", p0.rdata);
        @(negedge clk);

        // Randomized traffic against the reference model (addresses 64..79, fresh reset).
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 64'd0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        rq[0] = '0;
        rq[1] = '0;
        phase = 0;
        lastg = 1;
        cur_port = 0; cur_we = 1'b0; cur_acc = 1'b0; cur_err = 1'b0; cur_rdata = 64'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    rq[p].we    = 1'($urandom_range(0, 1));
                    rq[p].width = 3'($urandom_range(0, 5));
                    rq[p].addr  = 10'(64 + $urandom_range(0, 15));
                    rq[p].wdata = {$urandom, $urandom};
                    pend[p] = 1'b1;
                end
            end
            drive(0, pend[0], rq[0]);
            drive(1, pend[1], rq[1]);
            #1;
            g = -1;
            if (phase == 0) begin
                if (pend[0] && pend[1]) g = 1 - lastg;
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
            end
            check("rnd_p0_ready", p0.ready, g == 0);
            check("rnd_p1_ready", p1.ready, g == 1);
            check("rnd_mem_we", mem_we, (phase == 1) && cur_acc && cur_we);
            check("rnd_mem_re", mem_re, (phase == 1) && cur_acc && !cur_we);
            for (int p = 0; p < 2; p++) begin
                rv = (phase == 2) && (cur_port == p);
                check($sformatf("rnd_p%0d_resp_valid", p), rvld(p), rv);
                check($sformatf("rnd_p%0d_rdata", p), rdat(p), rv ? cur_rdata : 64'd0);
                check($sformatf("rnd_p%0d_err", p), rerr(p), rv ? cur_err : 1'b0);
            end
            if (phase == 2) begin
                $display("txn rnd port=%0d we=%0d acc=%0d rdata=0x%0h err=%0d",
                         cur_port, cur_we, cur_acc, rdat(cur_port), rerr(cur_port));
            end
            if (g >= 0) begin
                cur_port = g;
                cur_we   = rq[g].we;
                cur_acc  = rq[g].width < 3'd4;
                if (cur_acc) begin
                    nb = 1 << rq[g].width;
                    if (MIS && (int'(rq[g].addr) % nb) != 0) cur_acc = 1'b0;
                end
                cur_err   = !cur_acc;
                cur_rdata = 64'd0;
                if (cur_acc) begin
                    if (cur_we)
                        ref_mem[rq[g].addr - 10'd64] = (ref_mem[rq[g].addr - 10'd64] & ~byte_mask(rq[g].width)) |
                                                      (rq[g].wdata & byte_mask(rq[g].width));
                    else
                        cur_rdata = ref_mem[rq[g].addr - 10'd64] & byte_mask(rq[g].width);
                end
                pend[g] = 1'b0;
                lastg   = g;
                phase   = 1;
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2) begin
                phase = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
